vga_sprite_compositor: RTL

Parametrised successor to the single-purpose VGA pixel mux. The block takes the raster position from `vga_timings` and composites 1-bpp player and invader bitmaps, one laser and `NUM_MISSILES` missiles into an 8-bit RGB332 pixel. It sits between `vga_timings` and the VGA pins. It reports collisions once per frame, as one-cycle pulses, to the game logic, and it owns the player hit-blink state machine.

---
 rtl/vga_sprite_compositor.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/vga_sprite_compositor.sv
// Two-stage RGB332 sprite compositor (player, invader grid, laser, missiles) with
// once-per-frame collision reports and the player hit-blink state machine.
module vga_sprite_compositor #(
    parameter int unsigned NUM_MISSILES  = 3,
    parameter int unsigned INV_ROWS      = 5,
    parameter int unsigned INV_COLS      = 11,
    parameter int unsigned SCALE_LOG2    = 1,
    parameter int unsigned PLAYER_W      = 16,
    parameter int unsigned PLAYER_H      = 8,
    parameter int unsigned INV_W         = 12,
    parameter int unsigned INV_H         = 8,
    parameter int unsigned PITCH_X_LOG2  = 5,
    parameter int unsigned PITCH_Y_LOG2  = 5,
    parameter int unsigned PROJ_W        = 2,
    parameter int unsigned PROJ_H        = 8,
    parameter int unsigned BLINK_TOGGLES = 6,
    parameter logic [7:0]  COLOR_PLAYER  = 8'h1C,
    parameter logic [7:0]  COLOR_FG      = 8'hFF
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [9:0]                            pix_x,
    input  logic [9:0]                            pix_y,
    input  logic                                  de,
    input  logic                                  frame,
    input  logic                                  blink_tick,
    input  logic [9:0]                            player_x,
    input  logic [9:0]                            player_y,
    input  logic [PLAYER_W*PLAYER_H-1:0]          player_bmp,
    input  logic [INV_W*INV_H-1:0]                inv_bmp,
    input  logic [9:0]                            invaders_x,
    input  logic [9:0]                            invaders_y,
    input  logic [INV_ROWS*INV_COLS-1:0]          alive,
    input  logic                                  laser_active,
    input  logic [9:0]                            laser_x,
    input  logic [9:0]                            laser_y,
    input  logic [NUM_MISSILES-1:0]               m_active,
    input  logic [10*NUM_MISSILES-1:0]            m_x,
    input  logic [10*NUM_MISSILES-1:0]            m_y,
    output logic [7:0]                            vga_out,
    output logic                                  inv_hit_valid,
    output logic [$clog2(INV_ROWS*INV_COLS)-1:0]  inv_hit_idx,
    output logic                                  player_hit_valid,
    output logic [NUM_MISSILES-1:0]               player_hit_mask,
    output logic                                  blinking
);

    localparam int unsigned IdxW = $clog2(INV_ROWS*INV_COLS);
    localparam int unsigned PbW  = $clog2(PLAYER_W*PLAYER_H);
    localparam int unsigned IbW  = $clog2(INV_W*INV_H);
    localparam int unsigned CntW = $clog2(BLINK_TOGGLES+1);

    localparam logic [10:0] PlayerWs = 11'(PLAYER_W << SCALE_LOG2);
    localparam logic [10:0] PlayerHs = 11'(PLAYER_H << SCALE_LOG2);
    localparam logic [10:0] InvWs    = 11'(INV_W << SCALE_LOG2);
    localparam logic [10:0] InvHs    = 11'(INV_H << SCALE_LOG2);
    localparam logic [10:0] InvCols  = 11'(INV_COLS);
    localparam logic [10:0] InvRows  = 11'(INV_ROWS);
    localparam logic [10:0] PitchXM  = 11'((1 << PITCH_X_LOG2) - 1);
    localparam logic [10:0] PitchYM  = 11'((1 << PITCH_Y_LOG2) - 1);
    localparam logic [10:0] ProjW    = 11'(PROJ_W);
    localparam logic [10:0] ProjH    = 11'(PROJ_H);
    localparam logic [CntW-1:0] CntLast = CntW'(BLINK_TOGGLES);

    typedef enum logic [1:0] {StIdle, StBlinkOff, StBlinkOn} blink_state_e;

    blink_state_e state_q;
    logic [CntW-1:0] cnt_q, cnt_inc;

    // Half-open [org, org+size); a negative 11-bit difference means pos < org.
    function automatic logic in_span(input logic [9:0] pos, input logic [9:0] org,
                                     input logic [10:0] size);
        logic [10:0] diff;
        diff = {1'b0, pos} - {1'b0, org};
        return !diff[10] && (diff < size);
    endfunction

    logic [10:0] p_dx, p_dy, i_dx, i_dy, i_col, i_row, i_ox, i_oy;
    logic [PbW-1:0] p_bit;
    logic [IbW-1:0] i_bit;
    logic [IdxW-1:0] i_idx;
    logic p_op, i_op, l_hit;
    logic [NUM_MISSILES-1:0] m_hit;

    always_comb begin
        p_dx  = {1'b0, pix_x} - {1'b0, player_x};
        p_dy  = {1'b0, pix_y} - {1'b0, player_y};
        p_bit = PbW'((p_dy >> SCALE_LOG2) * PLAYER_W + (p_dx >> SCALE_LOG2));
        p_op  = in_span(pix_x, player_x, PlayerWs) && in_span(pix_y, player_y, PlayerHs)
                && player_bmp[p_bit];

        i_dx  = {1'b0, pix_x} - {1'b0, invaders_x};
        i_dy  = {1'b0, pix_y} - {1'b0, invaders_y};
        i_col = i_dx >> PITCH_X_LOG2;
        i_row = i_dy >> PITCH_Y_LOG2;
        i_ox  = i_dx & PitchXM;
        i_oy  = i_dy & PitchYM;
        i_idx = IdxW'(i_row * INV_COLS + i_col);
        i_bit = IbW'((i_oy >> SCALE_LOG2) * INV_W + (i_ox >> SCALE_LOG2));
        i_op  = !i_dx[10] && !i_dy[10] && (i_col < InvCols) && (i_row < InvRows)
                && (i_ox < InvWs) && (i_oy < InvHs) && inv_bmp[i_bit] && alive[i_idx];

        l_hit = laser_active && in_span(pix_x, laser_x, ProjW) && in_span(pix_y, laser_y, ProjH);
        for (int k = 0; k < NUM_MISSILES; k++) begin
            m_hit[k] = m_active[k] && in_span(pix_x, m_x[10*k +: 10], ProjW)
                       && in_span(pix_y, m_y[10*k +: 10], ProjH);
        end
    end

    logic s1_de_q, s1_player_q, s1_inv_q, s1_laser_q;
    logic [IdxW-1:0] s1_idx_q;
    logic [NUM_MISSILES-1:0] s1_miss_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_de_q     <= 1'b0;
            s1_player_q <= 1'b0;
            s1_inv_q    <= 1'b0;
            s1_laser_q  <= 1'b0;
            s1_idx_q    <= '0;
            s1_miss_q   <= '0;
        end else begin
            s1_de_q     <= de;
            s1_player_q <= p_op;
            s1_inv_q    <= i_op;
            s1_laser_q  <= l_hit;
            s1_idx_q    <= i_idx;
            s1_miss_q   <= m_hit;
        end
    end

    logic player_vis;
    logic [7:0] pix_d;

    always_comb begin
        player_vis = s1_player_q && (state_q != StBlinkOff);
        pix_d      = 8'h00;
        if (s1_de_q) begin
            if (player_vis) begin
                pix_d = COLOR_PLAYER;
            end else if (s1_laser_q || (|s1_miss_q) || s1_inv_q) begin
                pix_d = COLOR_FG;
            end
        end
    end

    logic inv_lat_q;
    logic [IdxW-1:0] inv_lat_idx_q;
    logic [NUM_MISSILES-1:0] mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_out          <= 8'h00;
            inv_lat_q        <= 1'b0;
            inv_lat_idx_q    <= '0;
            mask_q           <= '0;
            inv_hit_valid    <= 1'b0;
            inv_hit_idx      <= '0;
            player_hit_valid <= 1'b0;
            player_hit_mask  <= '0;
        end else begin
            vga_out <= pix_d;
            if (frame) begin
                inv_hit_valid    <= inv_lat_q;
                player_hit_valid <= |mask_q;
                if (inv_lat_q) inv_hit_idx <= inv_lat_idx_q;
                if (|mask_q) player_hit_mask <= mask_q;
                inv_lat_q <= 1'b0;
                mask_q    <= '0;
            end else begin
                inv_hit_valid    <= 1'b0;
                player_hit_valid <= 1'b0;
                if (s1_de_q) begin
                    if (s1_laser_q && s1_inv_q && !inv_lat_q) begin
                        inv_lat_q     <= 1'b1;
                        inv_lat_idx_q <= s1_idx_q;
                    end
                    // Only an idle player is vulnerable; BLINK_ON is invulnerable.
                    if (s1_player_q && state_q == StIdle) mask_q <= mask_q | s1_miss_q;
                end
            end
        end
    end

    assign cnt_inc = cnt_q + CntW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            blinking <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (player_hit_valid) begin
                        state_q <= StBlinkOff;
                        cnt_q   <= '0;
                    end
                end
                StBlinkOff, StBlinkOn: begin
                    if (blink_tick) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == CntLast) state_q <= StIdle;
                        else if (state_q == StBlinkOff) state_q <= StBlinkOn;
                        else state_q <= StBlinkOff;
                    end
                end
                default: state_q <= StIdle;
            endcase
            blinking <= (state_q != StIdle);
        end
    end

endmodule
